// File: rtl/boot_pkg.sv
// Shared boot definitions: loader state encoding and the text base address
// that the processor also uses as its reset PC.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      WRITE = 3'd2,
      HOLD  = 3'd3,
      RUN   = 3'd4,
      ERR   = 3'd5
   } boot_state_e;

   // Must match the processor's PC reset value so the first fetch hits word 0.
   localparam logic [31:0] BOOT_BASE_ADDR = 32'h0040_0020;

   // Byte address of instruction word idx; wraps silently at 32 bits.
   function automatic logic [31:0] word_byte_addr(input logic [31:0] base,
                                                  input logic [31:0] idx);
      return base + (idx << 2);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word packer. The first byte of each word lands in
// [31:24]; the fourth byte completes the word and pulses word_full_o in the
// same cycle it is accepted, with word_o already holding the full word.
module byte_packer (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        clear_i,
   input  logic        accept_i,
   input  logic [7:0]  byte_i,
   output logic [31:0] word_o,
   output logic        word_full_o
);

   logic [23:0] shift_q, shift_d;
   logic [1:0]  idx_q, idx_d;

   assign word_o      = {shift_q, byte_i};
   assign word_full_o = accept_i && (idx_q == 2'd3);

   // Shift accepted bytes in; clear drops any partial word.
   always_comb begin
      shift_d = shift_q;
      idx_d   = idx_q;
      if (clear_i) begin
         shift_d = '0;
         idx_d   = '0;
      end else if (accept_i) begin
         shift_d = {shift_q[15:0], byte_i};
         idx_d   = idx_q + 2'd1;
      end
   end

   // Packer registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         shift_q <= '0;
         idx_q   <= '0;
      end else begin
         shift_q <= shift_d;
         idx_q   <= idx_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader. Packs a byte stream into words,
// writes them from BASE_ADDR upward and keeps the processor in start-up
// until HOLD_CYCLES after the final write.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, waiting for load_req; processor held
// LOAD  | accepting bytes (in_ready=1)
// WRITE | one-cycle instruction memory write of the packed word
// HOLD  | final word written, counting down before release
// RUN   | processor released, done=1; load_req starts a reload
// ERR   | misaligned end or overflow; processor held until load_req
module imem_loader
   import boot_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BOOT_BASE_ADDR,
   parameter int          MAX_WORDS   = 1024,
   parameter int          HOLD_CYCLES = 2,
   localparam int         WCW         = $clog2(MAX_WORDS + 1)
) (
   input  logic           clk,
   input  logic           start_up_n,
   input  logic           load_req,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [7:0]     in_byte,
   input  logic           in_last,
   output logic           imem_we,
   output logic [31:0]    imem_addr,
   output logic [31:0]    imem_wdata,
   output logic           proc_start_up,
   output logic [WCW-1:0] word_count,
   output logic           done,
   output logic           error
);

   // Hold timer counts HOLD_CYCLES-1 down to 0.
   localparam int HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   boot_state_e    state_q, state_d;
   logic           in_ready_q, in_ready_d;
   logic           imem_we_q, imem_we_d;
   logic [31:0]    imem_addr_q, imem_addr_d;
   logic [31:0]    imem_wdata_q, imem_wdata_d;
   logic           start_up_q, start_up_d;
   logic [WCW-1:0] word_count_q, word_count_d;
   logic           done_q, done_d;
   logic           error_q, error_d;
   logic           last_q, last_d;
   logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

   logic           accept;
   logic           pack_clear;
   logic [31:0]    packed_word;
   logic           word_full;
   logic [WCW-1:0] wc_inc;

   assign accept = in_valid && in_ready_q;
   assign wc_inc = word_count_q + WCW'(1);

   byte_packer u_packer (
      .clk_i       (clk),
      .rst_ni      (start_up_n),
      .clear_i     (pack_clear),
      .accept_i    (accept),
      .byte_i      (in_byte),
      .word_o      (packed_word),
      .word_full_o (word_full)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d      = state_q;
      in_ready_d   = in_ready_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      start_up_d   = start_up_q;
      word_count_d = word_count_q;
      done_d       = done_q;
      error_d      = error_q;
      last_d       = last_q;
      hold_cnt_d   = hold_cnt_q;
      pack_clear   = 1'b0;

      case (state_q)
         IDLE, RUN, ERR: begin
            if (load_req) begin
               state_d      = LOAD;
               in_ready_d   = 1'b1;
               start_up_d   = 1'b1;
               word_count_d = '0;
               done_d       = 1'b0;
               error_d      = 1'b0;
               last_d       = 1'b0;
               pack_clear   = 1'b1;
            end
         end
         LOAD: begin
            if (accept) begin
               if (word_full) begin
                  state_d      = WRITE;
                  in_ready_d   = 1'b0;
                  imem_we_d    = 1'b1;
                  imem_addr_d  = word_byte_addr(BASE_ADDR, 32'(word_count_q));
                  imem_wdata_d = packed_word;
                  last_d       = in_last;
               end else if (in_last) begin
                  // Program ended mid-word.
                  state_d    = ERR;
                  in_ready_d = 1'b0;
                  error_d    = 1'b1;
                  pack_clear = 1'b1;
               end
            end
         end
         WRITE: begin
            word_count_d = wc_inc;
            if (last_q) begin
               state_d    = HOLD;
               hold_cnt_d = HCW'(HOLD_CYCLES - 1);
            end else if (wc_inc == WCW'(MAX_WORDS)) begin
               // Memory full but the stream has not ended.
               state_d = ERR;
               error_d = 1'b1;
            end else begin
               state_d    = LOAD;
               in_ready_d = 1'b1;
            end
         end
         HOLD: begin
            if (hold_cnt_q == '0) begin
               state_d    = RUN;
               start_up_d = 1'b0;
               done_d     = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt_q - HCW'(1);
            end
         end
         default: begin
            state_d    = IDLE;
            in_ready_d = 1'b0;
            start_up_d = 1'b1;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge start_up_n) begin
      if (!start_up_n) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b0;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= BASE_ADDR;
         imem_wdata_q <= '0;
         start_up_q   <= 1'b1;
         word_count_q <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         last_q       <= 1'b0;
         hold_cnt_q   <= '0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         start_up_q   <= start_up_d;
         word_count_q <= word_count_d;
         done_q       <= done_d;
         error_q      <= error_d;
         last_q       <= last_d;
         hold_cnt_q   <= hold_cnt_d;
      end
   end

   assign in_ready      = in_ready_q;
   assign imem_we       = imem_we_q;
   assign imem_addr     = imem_addr_q;
   assign imem_wdata    = imem_wdata_q;
   assign proc_start_up = start_up_q;
   assign word_count    = word_count_q;
   assign done          = done_q;
   assign error         = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table-driven loads, hand sequences for reset,
// overflow and reload corners, and randomized loads against a word-level
// model of the expected memory image.
module tb_imem_loader;

   localparam logic [31:0] BASE = 32'h0040_0020;
   localparam int          HOLD = 2;

   logic        clk = 1'b0;
   logic        start_up_n = 1'b0;
   logic        load_req = 1'b0;
   logic        in_valid = 1'b0;
   logic [7:0]  in_byte = 8'h00;
   logic        in_last = 1'b0;

   logic        in_ready1, imem_we1, proc_start_up1, done1, error1;
   logic [31:0] imem_addr1, imem_wdata1;
   logic [10:0] word_count1;

   logic        in_ready2, imem_we2, proc_start_up2, done2, error2;
   logic [31:0] imem_addr2, imem_wdata2;
   logic [1:0]  word_count2;

   always #5 clk = ~clk;

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(1024), .HOLD_CYCLES(HOLD)) dut (
      .clk(clk), .start_up_n(start_up_n), .load_req(load_req),
      .in_valid(in_valid), .in_ready(in_ready1), .in_byte(in_byte), .in_last(in_last),
      .imem_we(imem_we1), .imem_addr(imem_addr1), .imem_wdata(imem_wdata1),
      .proc_start_up(proc_start_up1), .word_count(word_count1),
      .done(done1), .error(error1)
   );

   imem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(2), .HOLD_CYCLES(HOLD)) dut2 (
      .clk(clk), .start_up_n(start_up_n), .load_req(load_req),
      .in_valid(in_valid), .in_ready(in_ready2), .in_byte(in_byte), .in_last(in_last),
      .imem_we(imem_we2), .imem_addr(imem_addr2), .imem_wdata(imem_wdata2),
      .proc_start_up(proc_start_up2), .word_count(word_count2),
      .done(done2), .error(error2)
   );

   typedef struct {
      int n_bytes;
      int gap;
      int exp_wc;
      bit exp_err;
   } vec_t;

   int          n_pass = 0;
   int          n_tot  = 0;
   int          cyc = 0;
   int          last_we_cyc = 0;
   int          fall_cyc = -100;
   bit          prev_su = 1'b1;
   int          n_we2 = 0;
   logic [31:0] last_a2 = '0;
   logic [31:0] last_d2 = '0;
   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [7:0]  stim_q[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tot++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h want %h", nm, act, exp);
   endtask

   task automatic fail(input string nm);
      n_tot++;
      $display("FAIL %s: wait bound expired", nm);
   endtask

   // One clock: advance to the next falling edge and log what happened.
   task automatic tick();
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (imem_we1) begin
         wa_q.push_back(imem_addr1);
         wd_q.push_back(imem_wdata1);
         last_we_cyc = cyc;
      end
      if (imem_we2) begin
         n_we2++;
         last_a2 = imem_addr2;
         last_d2 = imem_wdata2;
      end
      if (prev_su && !proc_start_up1) fall_cyc = cyc;
      prev_su = proc_start_up1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      start_up_n = 1'b0;
      load_req = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_byte = 8'h00;
      tick(); tick();
      start_up_n = 1'b1;
      tick();
      prev_su = proc_start_up1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last, input bit use2, output bit ok);
      bit rdy;
      ok = 1'b0;
      in_valid = 1'b1; in_byte = b; in_last = last;
      for (int t = 0; t < 40; t++) begin
         rdy = use2 ? in_ready2 : in_ready1;
         tick();
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic pulse_load();
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
   endtask

   // Stream stim_q (in_last on the final byte) and compare with the model:
   // complete words go to BASE+4i big-endian; a trailing partial word is an error.
   task automatic run_load(input string tag, input int gap);
      int  n;
      int  exp_w;
      bit  exp_err;
      bit  ok;
      int  t;
      logic [31:0] w;
      n = stim_q.size();
      exp_w = n / 4;
      exp_err = (n % 4) != 0;
      wa_q.delete(); wd_q.delete();
      fall_cyc = -100;
      pulse_load();
      for (int i = 0; i < n; i++) begin
         if (gap == 1 && i > 0) tick();
         else if (gap == 2 && $urandom_range(0, 2) == 0) tick();
         send_byte(stim_q[i], i == n - 1, 1'b0, ok);
         if (!ok) begin
            fail({tag, ".accept"});
            break;
         end
      end
      t = 0;
      while (!done1 && !error1 && t < 20) begin
         tick();
         t++;
      end
      if (t >= 20) fail({tag, ".finish"});
      chk({tag, ".done"}, 32'(done1), 32'(!exp_err));
      chk({tag, ".error"}, 32'(error1), 32'(exp_err));
      chk({tag, ".start_up"}, 32'(proc_start_up1), 32'(exp_err));
      chk({tag, ".word_count"}, 32'(word_count1), 32'(exp_w));
      chk({tag, ".n_writes"}, 32'(wa_q.size()), 32'(exp_w));
      for (int i = 0; i < exp_w && i < wa_q.size(); i++) begin
         w = {stim_q[4*i], stim_q[4*i+1], stim_q[4*i+2], stim_q[4*i+3]};
         chk($sformatf("%s.addr%0d", tag, i), wa_q[i], BASE + 32'(4 * i));
         chk($sformatf("%s.data%0d", tag, i), wd_q[i], w);
      end
      if (!exp_err && wa_q.size() > 0)
         chk({tag, ".release_lat"}, 32'(fall_cyc - last_we_cyc), 32'(HOLD + 1));
   endtask

   task automatic load_plan_bytes();
      stim_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h0C};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t tbl[9];
      bit   ok;
      bit   ready_seen;

      tbl[0] = '{8, 0, 2, 1'b0};
      tbl[1] = '{8, 1, 2, 1'b0};
      tbl[2] = '{6, 0, 1, 1'b1};
      tbl[3] = '{4, 0, 1, 1'b0};
      tbl[4] = '{1, 0, 0, 1'b1};
      tbl[5] = '{3, 1, 0, 1'b1};
      tbl[6] = '{16, 1, 4, 1'b0};
      tbl[7] = '{13, 0, 3, 1'b1};
      tbl[8] = '{20, 2, 5, 1'b0};

      // Reset values, sampled while reset is held.
      @(posedge clk);
      @(negedge clk);
      chk("rst.in_ready", 32'(in_ready1), 32'd0);
      chk("rst.imem_we", 32'(imem_we1), 32'd0);
      chk("rst.imem_addr", imem_addr1, BASE);
      chk("rst.imem_wdata", imem_wdata1, 32'd0);
      chk("rst.start_up", 32'(proc_start_up1), 32'd1);
      chk("rst.word_count", 32'(word_count1), 32'd0);
      chk("rst.done", 32'(done1), 32'd0);
      chk("rst.error", 32'(error1), 32'd0);

      // Table-driven loads.
      for (int k = 0; k < 9; k++) begin
         do_reset();
         stim_q.delete();
         for (int i = 0; i < tbl[k].n_bytes; i++) stim_q.push_back(8'((k * 53 + i * 29 + 7) & 255));
         run_load($sformatf("tbl%0d", k), tbl[k].gap);
         chk($sformatf("tbl%0d.exp_wc", k), 32'(word_count1), 32'(tbl[k].exp_wc));
         chk($sformatf("tbl%0d.exp_err", k), 32'(error1), 32'(tbl[k].exp_err));
      end

      // Reference program, back-to-back and with gaps.
      for (int g = 0; g < 2; g++) begin
         do_reset();
         load_plan_bytes();
         run_load($sformatf("plan%0d", g), g);
         if (wa_q.size() == 2) begin
            chk("plan.addr0", wa_q[0], 32'h0040_0020);
            chk("plan.data0", wd_q[0], 32'h2008_0005);
            chk("plan.addr1", wa_q[1], 32'h0040_0024);
            chk("plan.data1", wd_q[1], 32'h0000_000C);
         end else begin
            chk("plan.writes", 32'(wa_q.size()), 32'd2);
         end
         chk("plan.latency", 32'(fall_cyc - last_we_cyc), 32'd3);
      end

      // Reload from RUN: start-up reasserted the next cycle.
      chk("run.done", 32'(done1), 32'd1);
      chk("run.start_up", 32'(proc_start_up1), 32'd0);
      pulse_load();
      chk("reload.start_up", 32'(proc_start_up1), 32'd1);
      chk("reload.done", 32'(done1), 32'd0);
      chk("reload.in_ready", 32'(in_ready1), 32'd1);
      stim_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
      run_load("reload", 0);

      // Overflow on the two-word instance.
      do_reset();
      n_we2 = 0;
      pulse_load();
      for (int i = 0; i < 8; i++) begin
         send_byte(8'(8'h10 + i), 1'b0, 1'b1, ok);
         if (!ok) begin
            fail("ovf.accept");
            break;
         end
      end
      tick();
      chk("ovf.error", 32'(error2), 32'd1);
      chk("ovf.n_writes", 32'(n_we2), 32'd2);
      chk("ovf.addr", last_a2, BASE + 32'd4);
      chk("ovf.data", last_d2, 32'h1415_1617);
      chk("ovf.word_count", 32'(word_count2), 32'd2);
      ready_seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         in_valid = 1'b1; in_byte = 8'(8'h18 + i);
         if (in_ready2) ready_seen = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("ovf.ready_low", 32'(ready_seen), 32'd0);
      chk("ovf.no_more_writes", 32'(n_we2), 32'd2);
      chk("ovf.start_up", 32'(proc_start_up2), 32'd1);
      chk("ovf.done", 32'(done2), 32'd0);

      // Asynchronous reset in the middle of the second word.
      do_reset();
      load_plan_bytes();
      pulse_load();
      for (int i = 0; i < 6; i++) begin
         send_byte(stim_q[i], 1'b0, 1'b0, ok);
         if (!ok) begin
            fail("midrst.accept");
            break;
         end
      end
      chk("midrst.pre_ready", 32'(in_ready1), 32'd1);
      #2 start_up_n = 1'b0;
      #1;
      chk("midrst.in_ready", 32'(in_ready1), 32'd0);
      chk("midrst.imem_we", 32'(imem_we1), 32'd0);
      chk("midrst.imem_addr", imem_addr1, BASE);
      chk("midrst.imem_wdata", imem_wdata1, 32'd0);
      chk("midrst.start_up", 32'(proc_start_up1), 32'd1);
      chk("midrst.word_count", 32'(word_count1), 32'd0);
      chk("midrst.done", 32'(done1), 32'd0);
      chk("midrst.error", 32'(error1), 32'd0);
      @(negedge clk);
      start_up_n = 1'b1;
      tick();
      prev_su = proc_start_up1;
      stim_q = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h01, 8'h02, 8'h03, 8'h04};
      run_load("midrst.reload", 0);

      // Randomized loads back to back, without reset between them.
      for (int r = 0; r < 12; r++) begin
         int n;
         n = $urandom_range(1, 30);
         stim_q.delete();
         for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom));
         run_load($sformatf("rnd%0d", r), 2);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

endmodule
